stream_demux_1ton: RTL and testbench
====================================

// Module: stream_demux_1toN
// PURPOSE
//  Packet-aware 1-to-N stream demultiplexer with valid/ready handshake; the
//  routing counterpart of the 2:1 output mux. Steers each input packet to the
//  output selected on the packet's first beat and holds that route until
//  in_last. Each output has a one-entry register slice. Sits between a shared
//  source stream and per-channel consumers.
// PARAMETERS
//  NUM_OUT  2   number of output channels (>=2)
//  DATA_W   8   data width per beat
//  CNT_W    16  width of the dropped-packet counter
//  SEL_W    localparam = max(1, $clog2(NUM_OUT)); not overridable
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               async active-low reset
//  in_valid   in   1               input beat valid
//  in_ready   out  1               input beat accepted when in_valid&&in_ready
//  in_data    in   DATA_W          input beat data
//  in_last    in   1               last beat of packet
//  in_sel     in   SEL_W           target channel; sampled on first beat only
//  out_valid  out  NUM_OUT         per-channel beat valid
//  out_ready  in   NUM_OUT         per-channel consumer ready
//  out_data   out  NUM_OUT*DATA_W  channel i at [i*DATA_W +: DATA_W]
//  out_last   out  NUM_OUT         per-channel last flag
//  busy       out  1               1 while a packet is mid-route (ROUTE/DROP)
//  drop_cnt   out  CNT_W           count of packets dropped for bad in_sel
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, out_data=0, out_last=0,
//   drop_cnt=0, busy=0, locked sel=0. Takes effect immediately, also mid-packet;
//   partial packet is discarded, no beat is emitted after release.
//  FSM states:
//   IDLE : tgt=in_sel. On accepted beat: in_sel<NUM_OUT -> load slice[tgt];
//          in_last=0 -> ROUTE (lock sel); in_last=1 -> stay IDLE.
//          in_sel>=NUM_OUT -> beat discarded, drop_cnt+1; in_last=0 -> DROP.
//   ROUTE: tgt=locked sel; in_sel ignored. Accepted beat loads slice[tgt];
//          accepted beat with in_last=1 -> IDLE.
//   DROP : in_ready=1, beats discarded, no output activity; in_last -> IDLE.
//  in_ready (IDLE/ROUTE, valid tgt) = !out_valid[tgt] || out_ready[tgt];
//   combinational from out_ready; no dependency on in_valid. In IDLE with bad
//   in_sel, in_ready=1.
//  Slice i: load -> out_valid[i]=1, out_data/out_last captured next edge.
//   Drain (out_valid&&out_ready) without load -> out_valid[i]=0. Simultaneous
//   drain+load -> new beat replaces old, out_valid stays 1 (full throughput).
//   out_data/out_last hold while out_valid=1 && out_ready=0.
//  Latency: 1 cycle input accept -> out_valid. Throughput 1 beat/cycle.
//   Back-to-back packets to different channels need no bubble.
//  Only slice[tgt] may load in a cycle; other channels drain independently.
//  drop_cnt saturates at all-ones; it counts packets, not beats.
//  busy = (state != IDLE), registered.
//  Bad in_sel can occur only when NUM_OUT is not a power of two.
// STRUCTURE
//  demux_pkg: state enum {IDLE, ROUTE, DROP}, sel_width() function
//   (max(1,$clog2(n))).
//  Sub-module demux_out_slice (one-entry valid/ready register, DATA_W+1 bits),
//   instantiated NUM_OUT times via generate. Top holds FSM, locked sel,
//   in_ready logic, drop counter.
// TESTING
//  1 Reset mid-packet: 2 beats of 4-beat pkt to ch1, pull rst_n low between
//    edges -> out_valid=0 at once, busy=0; after release nothing on ch1.
//  2 Single beat sel=1 data=0xA5 last=1, out_ready=2'b11 -> next cycle
//    out_valid=2'b10, ch1 data=0xA5 last=1; state stays IDLE.
//  3 3-beat pkt sel=0 data 0x11,0x22,0x33, in_sel driven 1 on beats 2-3 ->
//    all 3 beats on ch0 in order, last only on 0x33; ch1 idle.
//  4 Backpressure: out_ready[0]=0, send 0x01,0x02 to ch0 -> 0x01 held,
//    in_ready=0; out_ready[0]=1 -> 0x01 then 0x02 out, no loss or duplicate.
//  5 NUM_OUT=3, sel=3, 2-beat pkt -> in_ready=1 both beats, no out_valid,
//    drop_cnt 0->1; preload CNT_W=4 at 4'hF -> stays 4'hF.
//  6 Pkt A (2 beats) to ch0, next cycle pkt B (1 beat) to ch1, all ready=1 ->
//    3 consecutive accepts, in_ready=1 throughout, ch1 valid 1 cycle after B.

Source files
------------

// File: rtl/stream_demux_1ton_pkg.sv
// Shared types and helpers for the packet-aware 1-to-N stream demultiplexer.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_1ton_out_slice.sv
// One-entry valid/ready register slice for a single demux output channel.
module demux_out_slice #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  // A load in the same cycle as a drain replaces the entry, so valid stays high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/stream_demux_1ton.sv
// Packet-aware 1-to-N valid/ready demultiplexer: routes each packet to the
// channel chosen on its first beat, drops packets addressed to absent channels.
module stream_demux_1ton
  import demux_pkg::*;
#(
  parameter int unsigned NUM_OUT = 2,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned SEL_W  = sel_width(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_last,
  output logic                      busy,
  output logic [CNT_W-1:0]          drop_cnt
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               busy_q, busy_d;

  logic [SEL_W-1:0]   tgt;
  logic               tgt_ok;
  logic               tgt_ready;
  logic               accept;
  logic [NUM_OUT-1:0] load;

  // Target decode is done by comparison so an out-of-range in_sel never
  // indexes past the channel vectors.
  always_comb begin
    tgt       = (state_q == ROUTE) ? sel_q : in_sel;
    tgt_ok    = 1'b0;
    tgt_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (tgt == SEL_W'(i)) begin
        tgt_ok    = 1'b1;
        tgt_ready = !out_valid[i] || out_ready[i];
      end
    end
    in_ready = (state_q == DROP) || !tgt_ok || tgt_ready;
    accept   = in_valid && in_ready;
    load     = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      load[i] = accept && (state_q != DROP) && (tgt == SEL_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    drop_cnt_d = drop_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (tgt_ok) begin
            if (!in_last) begin
              state_d = ROUTE;
              sel_d   = tgt;
            end
          end else begin
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
            if (!in_last) state_d = DROP;
          end
        end
      end
      ROUTE, DROP: begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      drop_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      drop_cnt_q <= drop_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign drop_cnt = drop_cnt_q;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slice
    demux_out_slice #(
      .DATA_W (DATA_W)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_ready (out_ready[g]),
      .out_valid (out_valid[g]),
      .out_data  (out_data[g*DATA_W +: DATA_W]),
      .out_last  (out_last[g])
    );
  end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Scoreboard bench for stream_demux_1ton with three channels (one bad select code).
module tb_stream_demux_1ton;

  localparam int unsigned NOUT = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic [1:0]      in_sel;
  logic [NOUT-1:0] out_valid;
  logic [NOUT-1:0] out_ready;
  logic [NOUT*DW-1:0] out_data;
  logic [NOUT-1:0] out_last;
  logic            busy;
  logic [CW-1:0]   drop_cnt;

  stream_demux_1ton #(
    .NUM_OUT (NOUT),
    .DATA_W  (DW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_ready = 1'b0;

  // Reference model: packet-level routing decisions and per-channel expectations.
  logic [DW:0] exp_q0[$];
  logic [DW:0] exp_q1[$];
  logic [DW:0] exp_q2[$];
  bit          m_in_pkt = 1'b0;
  int          m_ch     = 0;
  int          m_drop   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    m_in_pkt = 1'b0;
    m_ch     = 0;
    m_drop   = 0;
  endtask

  task automatic model_accept(input int sel, input logic [DW-1:0] d, input logic l);
    if (!m_in_pkt) begin
      m_ch = (sel < int'(NOUT)) ? sel : -1;
      if (m_ch < 0) m_drop = (m_drop == 15) ? 15 : m_drop + 1;
    end
    case (m_ch)
      0: exp_q0.push_back({l, d});
      1: exp_q1.push_back({l, d});
      2: exp_q2.push_back({l, d});
      default: ;
    endcase
    m_in_pkt = !l;
  endtask

  function automatic int q_size(input int ch);
    case (ch)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  // Monitor: every output handshake pops that channel's expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int ch = 0; ch < int'(NOUT); ch++) begin
        if (out_valid[ch] && out_ready[ch]) begin
          logic [DW:0] got;
          logic [DW:0] exp;
          got = {out_last[ch], out_data[ch*DW +: DW]};
          if (q_size(ch) == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat ch%0d: got 0x%0h expected no beat at %0t", ch, got, $time);
          end else begin
            case (ch)
              0: exp = exp_q0.pop_front();
              1: exp = exp_q1.pop_front();
              default: exp = exp_q2.pop_front();
            endcase
            check($sformatf("beat_ch%0d", ch), 32'(got), 32'(exp));
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = NOUT'($urandom);
  end

  task automatic send_beat(input int sel, input logic [DW-1:0] d, input logic l, output int waits);
    in_valid = 1'b1;
    in_sel   = 2'(sel);
    in_data  = d;
    in_last  = l;
    waits    = 0;
    forever begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(m_in_pkt));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (in_ready) begin
        model_accept(sel, d, l);
        @(posedge clk);
        #1;
        break;
      end
      waits++;
      if (waits > 200) begin
        n_checks++;
        $display("FAIL accept_timeout: got in_ready=0 expected accept within 200 cycles");
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int w, w1, w2, w3;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_sel    = '0;
    out_ready = '1;
    model_reset();
    #12;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset in the middle of a packet to ch1.
    send_beat(1, 8'h10, 1'b0, w);
    send_beat(1, 8'h20, 1'b0, w);
    check("mid_busy", 32'(busy), 32'h1);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(out_valid), 32'h0);
    end
    @(posedge clk);
    #1;

    // Single-beat packet to ch1.
    send_beat(1, 8'hA5, 1'b1, w);
    check("single_valid", 32'(out_valid), 32'h2);
    check("single_data", 32'(out_data[DW +: DW]), 32'hA5);
    check("single_last", 32'(out_last[1]), 32'h1);
    check("single_busy", 32'(busy), 32'h0);

    // Route locks on the first beat; later in_sel values are ignored.
    send_beat(0, 8'h11, 1'b0, w);
    send_beat(1, 8'h22, 1'b0, w);
    send_beat(1, 8'h33, 1'b1, w);
    @(negedge clk);
    check("lock_ch1_idle", 32'(out_valid[1]), 32'h0);
    @(posedge clk);
    #1;

    // Backpressure on ch0 holds the first beat and stalls the input.
    out_ready = 3'b110;
    send_beat(0, 8'h01, 1'b0, w);
    fork
      send_beat(0, 8'h02, 1'b1, w);
      begin
        @(negedge clk);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'h0);
        check("bp_hold_data", 32'(out_data[DW-1:0]), 32'h01);
        @(posedge clk);
        #2;
        @(negedge clk);
        #1;
        check("bp_in_ready2", 32'(in_ready), 32'h0);
        check("bp_hold_valid", 32'(out_valid[0]), 32'h1);
        @(posedge clk);
        #2 out_ready = 3'b111;
      end
    join
    check("bp_waited", 32'(w >= 2), 32'h1);
    repeat (2) @(posedge clk);
    #1;

    // Packets to the absent channel 3 are swallowed and counted.
    send_beat(3, 8'hE1, 1'b0, w1);
    send_beat(3, 8'hE2, 1'b1, w2);
    check("drop_ready_b1", 32'(w1), 32'h0);
    check("drop_ready_b2", 32'(w2), 32'h0);
    check("drop_no_valid", 32'(out_valid), 32'h0);
    check("drop_cnt_one", 32'(drop_cnt), 32'h1);
    for (int i = 0; i < 16; i++) send_beat(3, 8'(i), 1'b1, w);
    @(negedge clk);
    check("drop_cnt_sat", 32'(drop_cnt), 32'hF);
    @(posedge clk);
    #1;

    // Back-to-back packets to different channels run without bubbles.
    send_beat(0, 8'hA1, 1'b0, w1);
    send_beat(0, 8'hA2, 1'b1, w2);
    send_beat(1, 8'hB1, 1'b1, w3);
    check("b2b_w1", 32'(w1), 32'h0);
    check("b2b_w2", 32'(w2), 32'h0);
    check("b2b_w3", 32'(w3), 32'h0);
    check("b2b_ch1_valid", 32'(out_valid[1]), 32'h1);

    // Randomized traffic with random consumer backpressure.
    rand_ready = 1'b1;
    for (int p = 0; p < 120; p++) begin
      int sel0;
      int len;
      sel0 = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        int s;
        s = (b == 0) ? sel0 : int'($urandom_range(0, 3));
        send_beat(s, 8'($urandom), (b == len - 1), w);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = '1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_q0", 32'(exp_q0.size()), 32'h0);
    check("drain_q1", 32'(exp_q1.size()), 32'h0);
    check("drain_q2", 32'(exp_q2.size()), 32'h0);
    check("final_drop_cnt", 32'(drop_cnt), 32'(m_drop));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
